// File: rtl/neuron_act_collector.sv
// neuron_act_collector
//   Output stage of the time-multiplexed dot-product neuron. Each accepted
//   result passes through a fixed activation (identity, ReLU or leaky ReLU).
//   NUM_NEURONS consecutive results are collected into one layer vector.
//   The vector is handed to the next layer over a valid/ready handshake.
//   Two ping-pong banks let one vector fill while the other waits for the
//   consumer.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clear       synchronous flush of both banks, indices and overflow
//   valid_in    res_in carries the result for slot neuron_idx
//   res_in      signed neuron result
//   neuron_idx  slot the next accepted result is written to
//   vec_valid   vec_data holds a complete layer vector
//   vec_ready   consumer accepts vec_data
//   vec_data    element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   overflow    sticky: a result was dropped because both banks were full
module neuron_act_collector #(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_MODE    = 1,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             res_in,
  output logic [$clog2(NUM_NEURONS)-1:0]    neuron_idx,
  output logic                              vec_valid,
  input  logic                              vec_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] vec_data,
  output logic                              overflow
);

  localparam int IDX_W = $clog2(NUM_NEURONS);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e                      st_q [2];
  bank_st_e                      st_d [2];
  logic                          wr_bank_q, wr_bank_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          ovf_q, ovf_d;
  logic signed [DATA_WIDTH-1:0]  mem_q [2][NUM_NEURONS];

  logic signed [DATA_WIDTH-1:0]  act_y;
  logic                          wr_en;
  logic                          hs;
  logic                          last;

  // Arithmetic shift floors toward minus infinity, so -1 stays -1.
  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [DATA_WIDTH-1:0] y;
    y = x;
    if (x < 0) begin
      if (ACT_MODE == 1) begin
        y = '0;
      end else if (ACT_MODE == 2) begin
        y = x >>> LEAKY_SHIFT;
      end
    end
    return y;
  endfunction

  assign act_y = activate($signed(res_in));

  // The writer never targets a FULL bank, so a write and a handshake
  // can never hit the same bank in one cycle.
  assign wr_en     = valid_in && (st_q[wr_bank_q] != BANK_FULL);
  assign vec_valid = (st_q[rd_bank_q] == BANK_FULL);
  assign hs        = vec_valid && vec_ready;
  assign last      = (idx_q == IDX_W'(NUM_NEURONS - 1));

  // Stage p0: bank state / pointer next-state
  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    if (clear) begin
      st_d[0]   = BANK_EMPTY;
      st_d[1]   = BANK_EMPTY;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      idx_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      if (wr_en) begin
        if (last) begin
          st_d[wr_bank_q] = BANK_FULL;
          idx_d           = '0;
          wr_bank_d       = ~wr_bank_q;
        end else begin
          st_d[wr_bank_q] = BANK_FILLING;
          idx_d           = idx_q + IDX_W'(1);
        end
      end else if (valid_in) begin
        // A bank freed by this cycle's handshake is only writable next cycle.
        ovf_d = 1'b1;
      end
      if (hs) begin
        st_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d       = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= BANK_EMPTY;
      st_q[1]   <= BANK_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is cleared on reset so vec_data reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else if (wr_en && !clear) begin
      mem_q[wr_bank_q][idx_q] <= act_y;
    end
  end

  // Stage p1: read side
  always_comb begin
    vec_data = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      vec_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_bank_q][k];
    end
  end

  assign neuron_idx = idx_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_neuron_act_collector.sv
module tb_neuron_act_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        valid_in;
  logic [15:0] res_in;
  logic        vec_ready;

  logic [1:0]  r_idx, l_idx, i_idx;
  logic        r_vv, l_vv, i_vv;
  logic        r_ovf, l_ovf, i_ovf;
  logic [63:0] r_vd, l_vd, i_vd;

  int checks = 0;
  int fails  = 0;
  int n_vec  = 0;

  always #5 clk = ~clk;

  neuron_act_collector #(.NUM_NEURONS(4), .DATA_WIDTH(16), .ACT_MODE(1), .LEAKY_SHIFT(3)) u_relu (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .res_in(res_in),
    .neuron_idx(r_idx), .vec_valid(r_vv), .vec_ready(vec_ready), .vec_data(r_vd), .overflow(r_ovf));

  neuron_act_collector #(.NUM_NEURONS(4), .DATA_WIDTH(16), .ACT_MODE(2), .LEAKY_SHIFT(3)) u_leaky (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .res_in(res_in),
    .neuron_idx(l_idx), .vec_valid(l_vv), .vec_ready(vec_ready), .vec_data(l_vd), .overflow(l_ovf));

  neuron_act_collector #(.NUM_NEURONS(4), .DATA_WIDTH(16), .ACT_MODE(0), .LEAKY_SHIFT(3)) u_ident (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .res_in(res_in),
    .neuron_idx(i_idx), .vec_valid(i_vv), .vec_ready(vec_ready), .vec_data(i_vd), .overflow(i_ovf));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [15:0] e0, input logic [15:0] e1,
                                       input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [15:0] act(input int mode, input logic [15:0] x);
    if (mode == 0 || x[15] == 1'b0) return x;
    if (mode == 1) return 16'h0000;
    return 16'($signed(x) >>> 3);
  endfunction

  function automatic logic [63:0] act_vec(input int mode, input logic [63:0] raw);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = act(mode, raw[k*16 +: 16]);
    return r;
  endfunction

  // Reference model: raw (pre-activation) vectors queued in completion order.
  logic        m_full [2];
  logic        m_wr, m_rd, m_ovf;
  logic [1:0]  m_idx;
  logic [63:0] m_cur;
  logic [63:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_full[0] <= 1'b0;
      m_full[1] <= 1'b0;
      m_wr      <= 1'b0;
      m_rd      <= 1'b0;
      m_ovf     <= 1'b0;
      m_idx     <= 2'd0;
      m_cur     <= '0;
      exp_q.delete();
    end else begin
      if (valid_in) begin
        if (m_full[m_wr]) begin
          m_ovf <= 1'b1;
        end else begin
          m_cur[m_idx*16 +: 16] <= res_in;
          if (m_idx == 2'd3) begin
            m_full[m_wr] <= 1'b1;
            m_wr         <= ~m_wr;
            m_idx        <= 2'd0;
            exp_q.push_back({res_in, m_cur[47:0]});
          end else begin
            m_idx <= m_idx + 2'd1;
          end
        end
      end
      if (m_full[m_rd] && vec_ready) begin
        m_full[m_rd] <= 1'b0;
        m_rd         <= ~m_rd;
      end
    end
  end

  // Monitor: control outputs every cycle, vector contents on each handshake.
  always @(negedge clk) begin
    logic [63:0] raw;
    if (rst_n) begin
      chk("vec_valid", 64'(r_vv), 64'(m_full[m_rd]));
      chk("neuron_idx", 64'(r_idx), 64'(m_idx));
      chk("overflow", 64'(r_ovf), 64'(m_ovf));
      chk("ctrl_leaky_ident", 64'({l_vv, i_vv, l_ovf, i_ovf, l_idx, i_idx}),
          64'({m_full[m_rd], m_full[m_rd], m_ovf, m_ovf, m_idx, m_idx}));
      if (r_vv && vec_ready && !clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected_vector: got %h expected none", r_vd);
        end else begin
          raw = exp_q.pop_front();
          n_vec++;
          chk("sb_relu", r_vd, act_vec(1, raw));
          chk("sb_leaky", l_vd, act_vec(2, raw));
          chk("sb_ident", i_vd, act_vec(0, raw));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] x);
    valid_in = v;
    res_in   = x;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 16'h0);
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    logic v;
    rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; res_in = '0; vec_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_vec_valid", 64'(r_vv), 64'd0);
    chk("rst_vec_data", r_vd, 64'd0);
    chk("rst_overflow", 64'(r_ovf), 64'd0);
    chk("rst_idx", 64'(r_idx), 64'd0);

    // T1: ReLU with extremes, consumer always ready
    vec_ready = 1'b1;
    step(1'b1, 16'd5); step(1'b1, 16'hFFFD); step(1'b1, 16'd0);
    chk("t1_not_yet_valid", 64'(r_vv), 64'd0);
    step(1'b1, 16'h8000);
    chk("t1_valid", 64'(r_vv), 64'd1);
    chk("t1_relu", r_vd, pack(16'd5, 16'd0, 16'd0, 16'd0));
    chk("t1_leaky", l_vd, pack(16'd5, 16'hFFFF, 16'd0, 16'hF000));
    chk("t1_ident", i_vd, pack(16'd5, 16'hFFFD, 16'd0, 16'h8000));
    step(1'b0, 16'h0);
    chk("t1_consumed", 64'(r_vv), 64'd0);

    // T2: leaky slope 1/8 with floor rounding
    step(1'b1, 16'hFFC0); step(1'b1, 16'hFFFF); step(1'b1, 16'd100); step(1'b1, 16'hFFF7);
    chk("t2_leaky", l_vd, pack(16'hFFF8, 16'hFFFF, 16'd100, 16'hFFFE));
    chk("t2_relu", r_vd, pack(16'd0, 16'd0, 16'd100, 16'd0));
    chk("t2_ident", i_vd, pack(16'hFFC0, 16'hFFFF, 16'd100, 16'hFFF7));
    step(1'b0, 16'h0);

    // T3: backpressure fills both banks, ninth result dropped
    do_clear();
    vec_ready = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i));
    chk("t3_vec0_valid", 64'(r_vv), 64'd1);
    chk("t3_vec0", r_vd, pack(16'd1, 16'd2, 16'd3, 16'd4));
    for (int i = 5; i <= 8; i++) step(1'b1, 16'(i));
    chk("t3_vec0_stable", r_vd, pack(16'd1, 16'd2, 16'd3, 16'd4));
    chk("t3_no_ovf_yet", 64'(r_ovf), 64'd0);
    step(1'b1, 16'd9);
    chk("t3_overflow", 64'(r_ovf), 64'd1);
    chk("t3_idx_held", 64'(r_idx), 64'd0);
    chk("t3_vec0_still", r_vd, pack(16'd1, 16'd2, 16'd3, 16'd4));

    // T4: drain back-to-back, overflow sticky until clear
    vec_ready = 1'b1;
    step(1'b0, 16'h0);
    chk("t4_vec1_valid", 64'(r_vv), 64'd1);
    chk("t4_vec1", r_vd, pack(16'd5, 16'd6, 16'd7, 16'd8));
    step(1'b0, 16'h0);
    chk("t4_empty", 64'(r_vv), 64'd0);
    chk("t4_ovf_sticky", 64'(r_ovf), 64'd1);
    vec_ready = 1'b0;
    do_clear();
    chk("t4_ovf_cleared", 64'(r_ovf), 64'd0);

    // T5: clear and reset mid-fill
    vec_ready = 1'b1;
    step(1'b1, 16'd7); step(1'b1, 16'd8);
    chk("t5_partial_idx", 64'(r_idx), 64'd2);
    do_clear();
    chk("t5_clear_idx", 64'(r_idx), 64'd0);
    chk("t5_clear_valid", 64'(r_vv), 64'd0);
    step(1'b1, 16'd10); step(1'b1, 16'd20); step(1'b1, 16'd30); step(1'b1, 16'd40);
    chk("t5_clean_vec", r_vd, pack(16'd10, 16'd20, 16'd30, 16'd40));
    step(1'b0, 16'h0);
    step(1'b1, 16'd7); step(1'b1, 16'd8);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_idx", 64'(r_idx), 64'd0);
    chk("t5_rst_valid", 64'(r_vv), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 16'd11); step(1'b1, 16'd12); step(1'b1, 16'd13); step(1'b1, 16'd14);
    chk("t5_rst_clean_vec", r_vd, pack(16'd11, 16'd12, 16'd13, 16'd14));
    step(1'b0, 16'h0);

    // T6: random valid/ready gaps
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      vec_ready = ($urandom_range(0, 3) != 0);
      step(v, 16'($urandom));
      if (v) sent++;
      cyc++;
    end
    chk("t6_sent", 64'(sent), 64'd1000);
    vec_ready = 1'b1;
    repeat (4) step(1'b0, 16'h0);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
    chk("t6_vectors_seen", 64'(n_vec >= 200), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
